isq_ctrl: RTL and testbench

//  Issue-queue storage and allocation control; sits directly upstream of the priority-decoder (issue-select) stage.

---
 rtl/isq_pkg.sv | 31 +++
 rtl/isq_alloc.sv | 45 ++++
 rtl/isq_ctrl.sv | 119 +++++++++++
 tb/tb_isq_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/isq_pkg.sv
// Issue-queue shared definitions: geometry, line field positions and helpers.
// Reused by the issue-select stage to decode isq_lin_flat.
package isq_pkg;

  localparam int ISQ_DEPTH        = 64;
  localparam int ISQ_IDX_BITS_NUM = 6;
  localparam int INST_WIDTH       = 67;
  localparam int DSP_WIDTH        = 4;
  localparam int AFULL_THRESH     = 8;
  localparam int ISQ_LINE_WIDTH   = INST_WIDTH + ISQ_IDX_BITS_NUM + 2;
  localparam int CNT_W            = ISQ_IDX_BITS_NUM + 1;
  localparam int LANE_BITS        = $clog2(DSP_WIDTH);

  // Line layout, MSB first: {idx, vld, wat, inst}
  localparam int BIT_INST_WAT = INST_WIDTH;
  localparam int BIT_INST_VLD = INST_WIDTH + 1;
  localparam int BIT_IDX      = INST_WIDTH + 2;

  typedef logic [INST_WIDTH-1:0] inst_t;
  typedef logic [ISQ_DEPTH-1:0]  line_vec_t;

  function automatic logic [CNT_W-1:0] popcnt_lines(input line_vec_t v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/isq_alloc.sv
// Find-first-DSP_WIDTH free lines and hand them to the valid dispatch lanes
// in ascending lane order. Purely combinational.
module isq_alloc
  import isq_pkg::*;
(
  input  logic [ISQ_DEPTH-1:0]                i_free,
  input  logic [DSP_WIDTH-1:0]                i_lane_vld,
  output logic [DSP_WIDTH-1:0][ISQ_DEPTH-1:0] o_lane_slot,
  output logic [DSP_WIDTH-1:0]                o_lane_found
);

  logic [DSP_WIDTH-1:0][ISQ_DEPTH-1:0] w_slot;
  logic [DSP_WIDTH-1:0]                w_slot_ok;

  // w_slot[j] is the one-hot position of the j-th free line from the bottom
  always_comb begin
    logic [LANE_BITS:0] cnt;
    w_slot    = '0;
    w_slot_ok = '0;
    cnt       = '0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      if (i_free[i] && (cnt < (LANE_BITS+1)'(DSP_WIDTH))) begin
        w_slot[cnt[LANE_BITS-1:0]][i]  = 1'b1;
        w_slot_ok[cnt[LANE_BITS-1:0]] = 1'b1;
        cnt = cnt + (LANE_BITS+1)'(1);
      end
    end
  end

  // Valid lanes are ranked among themselves so gaps in i_lane_vld waste no slot
  always_comb begin
    logic [LANE_BITS:0] rank;
    o_lane_slot  = '0;
    o_lane_found = '0;
    rank         = '0;
    for (int k = 0; k < DSP_WIDTH; k++) begin
      if (i_lane_vld[k]) begin
        o_lane_slot[k]  = w_slot[rank[LANE_BITS-1:0]];
        o_lane_found[k] = w_slot_ok[rank[LANE_BITS-1:0]];
        rank = rank + (LANE_BITS+1)'(1);
      end
    end
  end

endmodule

// File: rtl/isq_ctrl.sv
// Issue-queue line storage, allocation, free counter and stall/flush control.
// Optional almost-full output enabled by defining ISQ_AFULL_EN.
module isq_ctrl
  import isq_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DSP_WIDTH*INST_WIDTH-1:0]     dsp_inst_flat,
  input  logic [DSP_WIDTH-1:0]                dsp_inst_vld,
  output logic                                dsp_stall,
  input  logic [ISQ_DEPTH-1:0]                set_inst_wat,
  input  logic [ISQ_DEPTH-1:0]                set_inst_val,
  input  logic                                flush,
  output logic [ISQ_DEPTH*ISQ_LINE_WIDTH-1:0] isq_lin_flat,
  output logic [CNT_W-1:0]                    isq_free_cnt,
  output logic                                isq_full
`ifdef ISQ_AFULL_EN
  ,
  output logic                                isq_afull
`endif
);

  logic [ISQ_DEPTH-1:0]                r_vld;
  logic [ISQ_DEPTH-1:0]                r_wat;
  inst_t                               r_inst [ISQ_DEPTH];
  logic [CNT_W-1:0]                    r_free_cnt;

  logic [CNT_W-1:0]                    w_n;
  logic [CNT_W-1:0]                    w_alloc_n;
  logic [CNT_W-1:0]                    w_free_cnt_nxt;
  logic [DSP_WIDTH-1:0][ISQ_DEPTH-1:0] w_lane_slot;
  logic [DSP_WIDTH-1:0]                w_lane_found;
  logic [ISQ_DEPTH-1:0]                w_wr_en;
  inst_t                               w_wr_data [ISQ_DEPTH];

  isq_alloc u_alloc (
    .i_free       (~r_vld),
    .i_lane_vld   (dsp_inst_vld),
    .o_lane_slot  (w_lane_slot),
    .o_lane_found (w_lane_found)
  );

  always_comb begin
    w_n = '0;
    for (int k = 0; k < DSP_WIDTH; k++) begin
      w_n = w_n + CNT_W'(dsp_inst_vld[k]);
    end
  end

  assign dsp_stall = (w_n > r_free_cnt) | flush;
  assign w_alloc_n = dsp_stall ? '0 : w_n;

  // Freed lines are counted only if they were actually valid
  assign w_free_cnt_nxt = flush ? CNT_W'(ISQ_DEPTH)
                                : r_free_cnt - w_alloc_n + popcnt_lines(set_inst_val & r_vld);

  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      w_wr_data[i] = '0;
      for (int k = 0; k < DSP_WIDTH; k++) begin
        if (!dsp_stall && w_lane_found[k] && w_lane_slot[k][i]) begin
          w_wr_en[i]   = 1'b1;
          w_wr_data[i] = dsp_inst_flat[INST_WIDTH*k +: INST_WIDTH];
        end
      end
    end
  end

  // Allocation targets only lines with registered vld=0, while issue/complete
  // clears only lines with vld=1, so writes and clears never meet on a line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld      <= '0;
      r_wat      <= '0;
      r_free_cnt <= CNT_W'(ISQ_DEPTH);
      for (int i = 0; i < ISQ_DEPTH; i++) begin
        r_inst[i] <= '0;
      end
    end else begin
      r_free_cnt <= w_free_cnt_nxt;
      if (flush) begin
        r_vld <= '0;
        r_wat <= '0;
      end else begin
        r_vld <= (r_vld & ~set_inst_val) | w_wr_en;
        r_wat <= (r_wat & ~(set_inst_val | set_inst_wat)) | w_wr_en;
      end
      for (int i = 0; i < ISQ_DEPTH; i++) begin
        if (w_wr_en[i]) begin
          r_inst[i] <= w_wr_data[i];
        end
      end
    end
  end

  for (genvar g = 0; g < ISQ_DEPTH; g++) begin : g_line
    assign isq_lin_flat[ISQ_LINE_WIDTH*g +: ISQ_LINE_WIDTH] =
      {ISQ_IDX_BITS_NUM'(g), r_vld[g], r_wat[g], r_inst[g]};
  end

  assign isq_free_cnt = r_free_cnt;
  assign isq_full     = (r_free_cnt == '0);

`ifdef ISQ_AFULL_EN
  logic r_afull;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_afull <= 1'b0;
    end else begin
      r_afull <= (w_free_cnt_nxt < CNT_W'(AFULL_THRESH));
    end
  end

  assign isq_afull = r_afull;
`endif

endmodule

// File: tb/tb_isq_ctrl.sv
// Directed scoreboard bench for isq_ctrl: stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_isq_ctrl;
  import isq_pkg::*;

  logic                                clk;
  logic                                rst_n;
  logic [DSP_WIDTH*INST_WIDTH-1:0]     dsp_inst_flat;
  logic [DSP_WIDTH-1:0]                dsp_inst_vld;
  logic                                dsp_stall;
  logic [ISQ_DEPTH-1:0]                set_inst_wat;
  logic [ISQ_DEPTH-1:0]                set_inst_val;
  logic                                flush;
  logic [ISQ_DEPTH*ISQ_LINE_WIDTH-1:0] isq_lin_flat;
  logic [CNT_W-1:0]                    isq_free_cnt;
  logic                                isq_full;
`ifdef ISQ_AFULL_EN
  logic                                isq_afull;
`endif

  isq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dsp_inst_flat (dsp_inst_flat),
    .dsp_inst_vld  (dsp_inst_vld),
    .dsp_stall     (dsp_stall),
    .set_inst_wat  (set_inst_wat),
    .set_inst_val  (set_inst_val),
    .flush         (flush),
    .isq_lin_flat  (isq_lin_flat),
    .isq_free_cnt  (isq_free_cnt),
`ifdef ISQ_AFULL_EN
    .isq_afull     (isq_afull),
`endif
    .isq_full      (isq_full)
  );

  typedef struct {
    int          due;
    string       name;
    logic        stall;
    logic [63:0] vld;
    logic [63:0] wat;
    logic [6:0]  cnt;
    logic        full;
    int          line;
    logic [66:0] inst;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] V62 = 64'h3FFF_FFFF_FFFF_FFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [66:0] mkp(input int v);
    return {3'b101, 32'hA5A5_0000, 32'(v)};
  endfunction

  function automatic logic [63:0] b(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [3:0] v, input int base, input logic [63:0] w,
                       input logic [63:0] c, input logic f);
    dsp_inst_vld = v;
    for (int k = 0; k < DSP_WIDTH; k++) begin
      dsp_inst_flat[INST_WIDTH*k +: INST_WIDTH] = mkp(base + k);
    end
    set_inst_wat = w;
    set_inst_val = c;
    flush        = f;
  endtask

  task automatic expect_now(input string nm, input logic st, input logic [63:0] v,
                            input logic [63:0] w, input int cnt, input logic fu,
                            input int line, input logic [66:0] inst);
    exp_t e;
    e.due = cyc; e.name = nm; e.stall = st; e.vld = v; e.wat = w;
    e.cnt = 7'(cnt); e.full = fu; e.line = line; e.inst = inst;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every snapshot due in this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t        e;
      logic [63:0] av;
      logic [63:0] aw;
      e = q.pop_front();
      for (int i = 0; i < ISQ_DEPTH; i++) begin
        av[i] = isq_lin_flat[ISQ_LINE_WIDTH*i + BIT_INST_VLD];
        aw[i] = isq_lin_flat[ISQ_LINE_WIDTH*i + BIT_INST_WAT];
      end
      chk({e.name, ".stall"}, 128'(dsp_stall), 128'(e.stall));
      chk({e.name, ".vld"}, 128'(av), 128'(e.vld));
      chk({e.name, ".wat"}, 128'(aw), 128'(e.wat));
      chk({e.name, ".free_cnt"}, 128'(isq_free_cnt), 128'(e.cnt));
      chk({e.name, ".full"}, 128'(isq_full), 128'(e.full));
      if (e.line >= 0) begin
        chk({e.name, ".inst"}, 128'(isq_lin_flat[ISQ_LINE_WIDTH*e.line +: INST_WIDTH]), 128'(e.inst));
        chk({e.name, ".idx"}, 128'(isq_lin_flat[ISQ_LINE_WIDTH*e.line + BIT_IDX +: ISQ_IDX_BITS_NUM]),
            128'(e.line));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    apply(4'b0000, 0, '0, '0, 1'b0);
    tick();
    expect_now("reset", 0, '0, '0, 64, 0, 37, '0);
    tick();
    rst_n = 1'b1;

    apply(4'b1111, 10, '0, '0, 1'b0);
    expect_now("t1_in", 0, '0, '0, 64, 0, -1, '0);
    tick();
    apply(4'b0101, 20, '0, '0, 1'b0);
    expect_now("t1", 0, 64'hF, 64'hF, 60, 0, 2, mkp(12));
    tick();
    apply(4'b0000, 0, '0, '0, 1'b0);
    expect_now("t2_l5", 0, 64'h3F, 64'h3F, 58, 0, 5, mkp(22));
    expect_now("t2_l4", 0, 64'h3F, 64'h3F, 58, 0, 4, mkp(20));
    tick();

    for (int j = 0; j < 14; j++) begin
      apply(4'b1111, 100 + 4*j, '0, '0, 1'b0);
      tick();
    end

    apply(4'b0111, 30, '0, '0, 1'b0);
    expect_now("t3_stall", 1, V62, V62, 2, 0, -1, '0);
    tick();
    apply(4'b0011, 30, '0, '0, 1'b0);
    expect_now("t3_hold", 0, V62, V62, 2, 0, 62, '0);
    tick();
    apply(4'b0001, 70, b(4), b(5), 1'b0);
    expect_now("t3_full", 1, ALL, ALL, 0, 1, 63, mkp(31));
    tick();
    apply(4'b0000, 0, b(7) | b(5), b(7) | b(5), 1'b0);
    expect_now("t4", 0, ~b(5), ~(b(4) | b(5)), 1, 0, 4, mkp(20));
    tick();
    apply(4'b0011, 40, '0, '0, 1'b0);
    expect_now("t5", 0, ~(b(5) | b(7)), ~(b(4) | b(5) | b(7)), 2, 0, -1, '0);
    tick();
    apply(4'b0000, 0, '0, b(10), 1'b0);
    expect_now("t5_refill", 0, ALL, ~b(4), 0, 1, 7, mkp(41));
    tick();
    apply(4'b0001, 50, '0, b(2), 1'b0);
    expect_now("free10", 0, ~b(10), ~(b(4) | b(10)), 1, 0, -1, '0);
    tick();
    apply(4'b1111, 60, ALL, b(3), 1'b1);
    expect_now("realloc", 1, ~b(2), ~(b(2) | b(4)), 1, 0, 10, mkp(50));
    tick();
    apply(4'b1111, 60, '0, '0, 1'b0);
    expect_now("flush", 0, '0, '0, 64, 0, -1, '0);
    tick();
    apply(4'b0000, 0, '0, '0, 1'b0);
    expect_now("post_flush", 0, 64'hF, 64'hF, 60, 0, 0, mkp(60));
    tick();

    apply(4'b1111, 80, '0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    expect_now("arst", 0, '0, '0, 64, 0, 0, '0);
    tick();
    apply(4'b0000, 0, '0, '0, 1'b0);
    expect_now("arst_hold", 0, '0, '0, 64, 0, -1, '0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 128'(q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
